// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: RAM handshake encoding and the word returned on a failed access.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam logic [31:0] MEM_ERR_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between the icache (reads) and dcache (reads/writes),
// holding each grant until the RAM completes and pulsing the winner's wait low for one cycle.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate,
    output logic        memerr
);
    // state  | meaning
    // IDLE   | no owner; arbitrate at the clock edge (also the bubble between transactions)
    // IGRANT | icache read owns the RAM port
    // DGRANT | dcache read or write owns the RAM port
    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} arb_state_t;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_t    state, state_next;
    logic [SW-1:0] starve;
    logic          d_req, ram_done, ram_err;
    logic [31:0]   done_word;

    assign d_req     = dREN | dWEN;
    assign ram_err   = (ramstate == ERROR);
    assign ram_done  = (ramstate == ACCESS) || ram_err;
    assign done_word = ram_err ? MEM_ERR_WORD : ramload;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        case (state)
            IDLE: begin
                if (d_req && !(iREN && starve == STARVE_MAX)) state_next = DGRANT;
                else if (iREN)                                state_next = IGRANT;
            end
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                // completion wins over a request drop in the same cycle
                if (ram_done) begin
                    dwait      = 1'b0;
                    dload      = (dWEN && !ram_err) ? '0 : done_word;
                    state_next = IDLE;
                end else if (!d_req) begin
                    state_next = IDLE;
                end
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (ram_done) begin
                    iwait      = 1'b0;
                    iload      = done_word;
                    state_next = IDLE;
                end else if (!iREN) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                               memerr <= 1'b0;
        else if (state != IDLE && ram_err)       memerr <= 1'b1;
    end

    // Counts dcache wins taken while the icache was left waiting.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve <= '0;
        end else if (state == IDLE) begin
            if (state_next == DGRANT)
                starve <= !iREN ? '0 : ((starve == STARVE_MAX) ? starve : starve + 1'b1);
            else if (state_next == IGRANT)
                starve <= '0;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized scoreboard bench for memory_arbiter: a transaction-level model plans each grant's
// RAM response and pushes the expected completion; a negedge monitor pops and compares.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int LIMIT = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
    ramstate_t   ramstate = FREE;
    logic        iwait, dwait, ramREN, ramWEN, memerr;
    logic [31:0] iload, dload, ramaddr, ramstore;

    memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
    );

    always #5 CLK = ~CLK;

    typedef struct { int port; logic [31:0] data; } exp_t;   // port: 1 = icache, 2 = dcache
    exp_t sb[$];
    exp_t mon_e;

    int n_total = 0, n_pass = 0;

    // model: owner of the RAM port this cycle / next cycle, starvation count, sticky error
    int owner = 0, owner_nx = 0, starve_m = 0, starve_nx = 0;
    bit memerr_m = 0, memerr_nx = 0;
    // plan of the current grant: BUSY cycles before completion, abort cycle, outcome
    int g_cyc = 0, g_lat = 0, g_abort = -1;
    bit g_err = 0, g_drop = 0;
    logic [31:0] g_load = '0;
    // cache-side requests
    bit i_pend = 0, d_pend = 0, d_w = 0, d_r = 0;
    logic [31:0] i_a = '0, d_a = '0, d_s = '0;
    // stimulus knobs
    bit rnd_en = 0, i_auto = 0, d_auto = 0, use_fix = 0;
    logic [31:0] fix_load = '0;
    int lat_lo = 0, lat_hi = 0, err_pct = 0, abort_pct = 0;
    // expected RAM-side outputs for the current cycle
    logic exp_ren = 1'b0, exp_wen = 1'b0;
    logic [31:0] exp_addr = '0, exp_store = '0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    endtask

    task automatic plan(int port);
        exp_t e;
        g_cyc  = 0;
        g_lat  = int'($urandom_range(lat_hi, lat_lo));
        g_load = use_fix ? fix_load : $urandom;
        g_err  = (port == 1 || !d_w) && ($urandom_range(99) < err_pct);
        g_drop = g_err && ($urandom_range(1) == 1);
        g_abort = -1;
        if (g_lat > 0 && $urandom_range(99) < abort_pct) g_abort = int'($urandom_range(g_lat - 1));
        if (g_abort < 0) begin
            e.port = port;
            e.data = g_err ? MEM_ERR_WORD : ((port == 2 && d_w) ? 32'h0 : g_load);
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        bit done, aborted;
        @(posedge CLK);
        owner = owner_nx; starve_m = starve_nx; memerr_m = memerr_nx;
        #1;
        if (owner != 0 && (g_cyc == g_abort || (g_cyc == g_lat && g_drop))) begin
            if (owner == 1) i_pend = 0; else d_pend = 0;
        end
        if (!i_pend && owner != 1 && (i_auto || (rnd_en && $urandom_range(3) == 0))) begin
            i_pend = 1; i_a = $urandom;
        end
        if (!d_pend && owner != 2 && (d_auto || (rnd_en && $urandom_range(2) == 0))) begin
            d_pend = 1; d_a = $urandom; d_s = $urandom;
            d_w = d_auto ? 1'b0 : ($urandom_range(1) == 1);
            d_r = d_w ? ($urandom_range(1) == 1) : 1'b1;
        end
        iREN = i_pend; iaddr = i_a;
        dREN = d_pend && d_r; dWEN = d_pend && d_w; daddr = d_a; dstore = d_s;
        done = 0; aborted = 0;
        if (owner == 0) begin
            ramstate = ramstate_t'($urandom_range(3)); ramload = $urandom;
        end else if (g_cyc < g_lat) begin
            ramstate = BUSY; ramload = $urandom; aborted = (g_cyc == g_abort);
        end else begin
            ramstate = g_err ? ERROR : ACCESS; ramload = g_load; done = 1;
        end
        exp_ren = 1'b0; exp_wen = 1'b0; exp_addr = '0; exp_store = '0;
        if (owner == 1) begin
            exp_ren = iREN; exp_addr = iaddr;
        end else if (owner == 2) begin
            exp_wen = dWEN; exp_ren = dREN && !dWEN; exp_addr = daddr; exp_store = dstore;
        end
        owner_nx = owner; starve_nx = starve_m; memerr_nx = memerr_m;
        if (owner != 0) begin
            if (done) begin
                if (g_err) memerr_nx = 1;
                if (owner == 1) i_pend = 0; else d_pend = 0;
                owner_nx = 0;
            end else if (aborted) begin
                owner_nx = 0;
            end else begin
                g_cyc++;
            end
        end else if (d_pend && !(i_pend && starve_m == LIMIT)) begin
            owner_nx  = 2;
            starve_nx = i_pend ? ((starve_m < LIMIT) ? starve_m + 1 : LIMIT) : 0;
            plan(2);
        end else if (i_pend) begin
            owner_nx = 1; starve_nx = 0;
            plan(1);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            tick(); n++;
        end while (!(owner_nx == 0 && !i_pend && !d_pend) && n < 300);
        if (n >= 300) begin
            n_total++;
            $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
        end
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_iwait"}, 32'(iwait), 32'd1);
        check({tag, "_dwait"}, 32'(dwait), 32'd1);
        check({tag, "_iload"}, iload, 32'h0);
        check({tag, "_dload"}, dload, 32'h0);
        check({tag, "_ramREN"}, 32'(ramREN), 32'd0);
        check({tag, "_ramWEN"}, 32'(ramWEN), 32'd0);
        check({tag, "_ramaddr"}, ramaddr, 32'h0);
        check({tag, "_ramstore"}, ramstore, 32'h0);
        check({tag, "_memerr"}, 32'(memerr), 32'd0);
    endtask

    always @(negedge CLK) begin
        if (nRST) begin
            check("ramREN", 32'(ramREN), 32'(exp_ren));
            check("ramWEN", 32'(ramWEN), 32'(exp_wen));
            check("ramaddr", ramaddr, exp_addr);
            check("ramstore", ramstore, exp_store);
            check("memerr", 32'(memerr), 32'(memerr_m));
            if (owner != 1) check("iload_not_granted", iload, 32'h0);
            if (owner != 2) check("dload_not_granted", dload, 32'h0);
            if (owner == 0) begin
                check("waits_in_idle", {30'b0, iwait, dwait}, 32'd3);
            end else if (!iwait || !dwait) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_wait: got iwait=%b dwait=%b expected no pulse at %0t",
                             iwait, dwait, $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("wait_port", {30'b0, iwait, dwait}, (mon_e.port == 1) ? 32'd1 : 32'd2);
                    check((mon_e.port == 1) ? "iload" : "dload",
                          (mon_e.port == 1) ? iload : dload, mon_e.data);
                end
            end
        end
    end

    initial begin
        #2 nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 check_reset_outputs("reset");
        nRST = 1'b1;

        // dcache read, two BUSY cycles then ACCESS
        lat_lo = 2; lat_hi = 2; use_fix = 1; fix_load = 32'hDEADBEEF;
        d_pend = 1; d_r = 1; d_w = 0; d_a = 32'h100; d_s = 32'h0BAD_0000;
        wait_idle();

        // dcache write with dREN also high
        lat_lo = 0; lat_hi = 2; use_fix = 0;
        d_pend = 1; d_r = 1; d_w = 1; d_a = 32'h3100; d_s = 32'h12345678;
        wait_idle();

        // abort during BUSY, icache waiting behind it
        lat_lo = 3; lat_hi = 3; abort_pct = 100;
        d_pend = 1; d_r = 1; d_w = 0; d_a = 32'h200;
        tick();
        abort_pct = 0; lat_lo = 1; lat_hi = 2;
        i_pend = 1; i_a = 32'h40;
        wait_idle();

        // error completion on an icache read, then good traffic with memerr held
        err_pct = 100; lat_lo = 1; lat_hi = 1;
        i_pend = 1; i_a = 32'h80;
        wait_idle();
        err_pct = 0; lat_lo = 0; lat_hi = 2;
        d_pend = 1; d_r = 1; d_w = 0; d_a = 32'h300;
        wait_idle();
        i_pend = 1; i_a = 32'h84;
        wait_idle();

        // contention: icache held, dcache reissued after every completion
        lat_lo = 0; lat_hi = 1; i_auto = 1; d_auto = 1;
        repeat (40) tick();
        i_auto = 0; d_auto = 0;
        wait_idle();

        // async reset while dcache holds a grant with the starvation count at its limit
        lat_lo = 3; lat_hi = 3; i_auto = 1; d_auto = 1;
        begin
            int n = 0;
            do begin tick(); n++; end while (!(owner_nx == 2 && starve_nx == LIMIT) && n < 100);
            if (n >= 100) begin
                n_total++;
                $display("FAIL starve_buildup: got no saturated dcache grant expected one within %0d cycles", n);
            end
        end
        i_auto = 0; d_auto = 0;
        tick();
        #2 nRST = 1'b0;
        #1 check_reset_outputs("async_reset");
        sb.delete();
        owner = 0; owner_nx = 0; starve_m = 0; starve_nx = 0; memerr_m = 0; memerr_nx = 0;
        i_pend = 0; d_pend = 0;
        exp_ren = 1'b0; exp_wen = 1'b0; exp_addr = '0; exp_store = '0;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
        @(posedge CLK);
        #1 nRST = 1'b1;
        lat_lo = 0; lat_hi = 1;
        i_pend = 1; i_a = 32'h500;
        d_pend = 1; d_r = 1; d_w = 0; d_a = 32'h600;
        wait_idle();

        // randomized traffic
        rnd_en = 1; lat_lo = 0; lat_hi = 3; err_pct = 15; abort_pct = 15;
        repeat (3000) tick();
        rnd_en = 0;
        wait_idle();
        repeat (2) tick();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
